// File: rtl/dfp_pkg.sv
// Shared types and sizing for the decimal floating-point datapath.
// Holds the BCD digit type and the alignment state encoding.
package dfp_pkg;

   localparam int DIGITS = 7;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 4 * DIGITS;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } align_state_t;

endpackage

// File: rtl/dfp_digit_shr.sv
// One-digit BCD right shift with guard/sticky tracking; purely combinational.
// Shared by the aligner and, later, the rounder.
module dfp_digit_shr
   import dfp_pkg::*;
#(
   parameter int  DIGITS = dfp_pkg::DIGITS,
   localparam int MANT_W = 4 * DIGITS
) (
   input  logic [MANT_W-1:0] i_mant,
   input  bcd_digit_t        i_guard,
   input  logic              i_sticky,
   output logic [MANT_W-1:0] o_mant,
   output bcd_digit_t        o_guard,
   output logic              o_sticky
);

   // The previous guard digit falls into sticky as a new digit takes its place
   assign o_mant   = {4'b0000, i_mant[MANT_W-1:4]};
   assign o_guard  = i_mant[3:0];
   assign o_sticky = i_sticky | (i_guard != 4'd0);

endmodule

// File: rtl/dfp_align_shifter.sv
// Pre-add exponent alignment: swap so the larger exponent leads, then shift the
// smaller BCD mantissa one digit per cycle. Option macro: DFP_ALIGN_ZERO_SKIP_EN.
module dfp_align_shifter
   import dfp_pkg::*;
#(
   parameter int  DIGITS = dfp_pkg::DIGITS,
   parameter int  EXP_W  = dfp_pkg::EXP_W,
   localparam int MANT_W = 4 * DIGITS
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [EXP_W-1:0]  i_E_a,
   input  logic [EXP_W-1:0]  i_E_b,
   input  logic [MANT_W-1:0] i_M_a,
   input  logic [MANT_W-1:0] i_M_b,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [EXP_W-1:0]  o_E_out,
   output logic [MANT_W-1:0] o_M_big,
   output logic [MANT_W-1:0] o_M_small,
   output bcd_digit_t        o_guard,
   output logic              o_sticky,
   output logic              o_swapped
);

   localparam int REM_W = $clog2(DIGITS + 2);
   localparam logic [REM_W-1:0] REM_CAP  = REM_W'(DIGITS + 1);
   localparam logic [EXP_W-1:0] DIFF_CAP = EXP_W'(DIGITS + 1);

   align_state_t      r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [EXP_W-1:0]  r_E_out;
   logic [MANT_W-1:0] r_M_big;
   logic [MANT_W-1:0] r_M_small;
   bcd_digit_t        r_guard;
   logic              r_sticky;
   logic              r_swapped;
   logic [REM_W-1:0]  r_rem;

   logic              w_swap;
   logic [EXP_W-1:0]  w_E_big;
   logic [EXP_W-1:0]  w_E_small;
   logic [MANT_W-1:0] w_M_big;
   logic [MANT_W-1:0] w_M_small;
   logic [EXP_W-1:0]  w_diff;
   logic [REM_W-1:0]  w_rem_init;
   logic              w_skip;
   logic [MANT_W-1:0] w_shr_mant;
   bcd_digit_t        w_shr_guard;
   logic              w_shr_sticky;

   assign w_swap     = (i_E_a < i_E_b);
   assign w_E_big    = w_swap ? i_E_b : i_E_a;
   assign w_E_small  = w_swap ? i_E_a : i_E_b;
   assign w_M_big    = w_swap ? i_M_b : i_M_a;
   assign w_M_small  = w_swap ? i_M_a : i_M_b;
   assign w_diff     = w_E_big - w_E_small;

   // Beyond DIGITS+1 shifts every original digit is already folded into sticky
   assign w_rem_init = (w_diff > DIFF_CAP) ? REM_CAP : w_diff[REM_W-1:0];

`ifdef DFP_ALIGN_ZERO_SKIP_EN
   assign w_skip = (w_rem_init == '0) || (w_M_small == '0);
`else
   assign w_skip = (w_rem_init == '0);
`endif

   dfp_digit_shr #(
      .DIGITS   (DIGITS)
   ) u_digit_shr (
      .i_mant   (r_M_small),
      .i_guard  (r_guard),
      .i_sticky (r_sticky),
      .o_mant   (w_shr_mant),
      .o_guard  (w_shr_guard),
      .o_sticky (w_shr_sticky)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_E_out     <= '0;
         r_M_big     <= '0;
         r_M_small   <= '0;
         r_guard     <= '0;
         r_sticky    <= 1'b0;
         r_swapped   <= 1'b0;
         r_rem       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  r_E_out    <= w_E_big;
                  r_M_big    <= w_M_big;
                  r_M_small  <= w_M_small;
                  r_guard    <= '0;
                  r_sticky   <= 1'b0;
                  r_swapped  <= w_swap;
                  r_in_ready <= 1'b0;
                  if (w_skip) begin
                     r_rem       <= '0;
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_rem       <= w_rem_init;
                     r_state     <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_M_small <= w_shr_mant;
               r_guard   <= w_shr_guard;
               r_sticky  <= w_shr_sticky;
               r_rem     <= r_rem - REM_W'(1);
               if (r_rem == REM_W'(1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_E_out     = r_E_out;
   assign o_M_big     = r_M_big;
   assign o_M_small   = r_M_small;
   assign o_guard     = r_guard;
   assign o_sticky    = r_sticky;
   assign o_swapped   = r_swapped;

endmodule
